argmax_tree: RTL and testbench
==============================

# argmax_tree

Pipelined argmax reduction: from 2^S packed M-bit values, returns the largest value and its index. A balanced binary comparison tree with one register stage per level accepts a new vector every clock. It serves as the selection primitive for classifier output layers and max-pooling in the garbled-circuit synthesis library. The RTL module is named `argmax_tree`.

## Interface
- `S`, default 5: log2 of element count; 2^S elements; S >= 1.
- `M`, default 8: element width in bits; M >= 1.

- `clk`  input  1  clock; all state updates on rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `in_valid`  input  1  `in` is valid this cycle and is sampled.
- `in`  input  (2^S)*M  packed elements; element i = `in[(i+1)*M-1 : i*M]`.
- `out_valid`  output  1  `max`/`ind` carry a new result this cycle.
- `max`  output  M  largest element of the sampled vector.
- `ind`  output  S  index of that element.

## Operation
- Tree levels 1..S; level k holds 2^(S-k) candidate (value, index) pairs plus one valid bit.
- Level k candidate j = winner of level k-1 candidates 2j and 2j+1; level 0 = raw `in` with index i.
- Winner rule: right candidate (2j+1) wins only if strictly greater; ties go to the left, i.e. the lowest index among equal maxima.
- Comparison unsigned by default (see Configuration).
- Index width grows by one bit per level; the level-S index is exactly S bits, no truncation.
- Level-k valid = level k-1 valid delayed one cycle; level 0 valid = `in_valid`.
- Level data registers load only when their incoming valid is 1; otherwise they hold.
- `max`, `ind`, `out_valid` are the level-S registers directly; no combinational path from `in` to outputs.
- No backpressure: the block accepts one vector per cycle, with no stall or drop.

## Timing
- Reset (`rst` low, asynchronous): all valid bits 0, all candidate registers 0; `max`=0, `ind`=0, `out_valid`=0 immediately, without waiting for a clock edge.
- Latency: vector sampled at rising edge N (`in_valid`=1) produces `out_valid`=1 with its result after edge N+S-1. That is S register stages, including the capture edge.
- Throughput: 1 vector/cycle; back-to-back inputs give back-to-back outputs in order.
- `out_valid` is a single-cycle pulse per input; `max`/`ind` hold their last result while `out_valid`=0.
- Reset asserted mid-operation: all in-flight vectors are discarded; no `out_valid` for them after release.
- Reset release: the first edge with `rst` high may sample `in_valid`.

## Configuration
- `ARGMAX_SIGNED_EN` defined: elements are two's-complement; comparison is signed (8'h80 = -128 is the minimum).
- Not defined: comparison is unsigned (8'h80 = 128 exceeds 8'h7F).
- The tie rule and timing are identical in both modes.

## Test plan
- Reset check: hold `rst` low with arbitrary `in` -> `max`=0, `ind`=0, `out_valid`=0 asynchronously.
- Single max (S=5, M=8): all elements 10, element 17 = 99, `in_valid` pulse at edge N -> after edge N+4, `out_valid`=1, `max`=99, `ind`=17, then `out_valid`=0 with outputs held.
- Ties: elements 3, 20 and 31 = 200, others 5 -> `max`=200, `ind`=3. All elements equal 42 -> `ind`=0. Only element 31 = 255 -> `ind`=31.
- Streaming: 3 consecutive valid vectors with maxima 7@2, 88@30, 0 (all zero) -> 3 consecutive `out_valid` cycles giving (7,2), (88,30), (0,0).
- Mid-flight reset: `in_valid` at edge N, `rst` pulsed low between edges N+1 and N+2 -> no `out_valid` ever appears for that vector.
- Sign mode: element 0 = 8'h80, element 1 = 8'h7F, rest 0 -> unsigned: `max`=8'h80, `ind`=0; with `ARGMAX_SIGNED_EN`: `max`=8'h7F, `ind`=1.

Source files
------------

// File: rtl/argmax_tree.sv
// argmax_tree: pipelined argmax over 2^S packed M-bit elements.
// A balanced binary comparison tree with one register stage per level.
// Each level keeps its candidates' indices local to its own subtree, so the
// index grows by one bit per level and is absolute at the root.
// Optional feature: define ARGMAX_SIGNED_EN for two's-complement comparison
// (default build compares unsigned).
module argmax_tree #(
  parameter int S = 5,
  parameter int M = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [(2**S)*M-1:0]  in,
  output logic                 out_valid,
  output logic [M-1:0]         max,
  output logic [S-1:0]         ind
);

  // right candidate wins only when strictly greater, so ties keep the lower index
  function automatic logic right_wins(input logic [M-1:0] r, input logic [M-1:0] l);
`ifdef ARGMAX_SIGNED_EN
    return $signed(r) > $signed(l);
`else
    return r > l;
`endif
  endfunction

  for (genvar k = 1; k <= S; k++) begin : g_lvl
    localparam int N = 2**(S-k);

    logic [M-1:0] val [N];
    logic [k-1:0] idx [N];
    logic         vld;

    if (k == 1) begin : g_leaf
      // first level compares adjacent raw input elements on the capture edge
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          vld <= 1'b0;
          for (int j = 0; j < N; j++) begin
            val[j] <= '0;
            idx[j] <= '0;
          end
        end else begin
          vld <= in_valid;
          if (in_valid) begin
            for (int j = 0; j < N; j++) begin
              if (right_wins(in[(2*j+1)*M +: M], in[(2*j)*M +: M])) begin
                val[j] <= in[(2*j+1)*M +: M];
                idx[j] <= 1'b1;
              end else begin
                val[j] <= in[(2*j)*M +: M];
                idx[j] <= 1'b0;
              end
            end
          end
        end
      end
    end else begin : g_node
      // inner levels pick between the two child winners, prefixing the side bit
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          vld <= 1'b0;
          for (int j = 0; j < N; j++) begin
            val[j] <= '0;
            idx[j] <= '0;
          end
        end else begin
          vld <= g_lvl[k-1].vld;
          if (g_lvl[k-1].vld) begin
            for (int j = 0; j < N; j++) begin
              if (right_wins(g_lvl[k-1].val[2*j+1], g_lvl[k-1].val[2*j])) begin
                val[j] <= g_lvl[k-1].val[2*j+1];
                idx[j] <= {1'b1, g_lvl[k-1].idx[2*j+1]};
              end else begin
                val[j] <= g_lvl[k-1].val[2*j];
                idx[j] <= {1'b0, g_lvl[k-1].idx[2*j]};
              end
            end
          end
        end
      end
    end
  end

  assign out_valid = g_lvl[S].vld;
  assign max       = g_lvl[S].val[0];
  assign ind       = g_lvl[S].idx[0];

endmodule

// File: tb/tb_argmax_tree.sv
// tb_argmax_tree: scoreboard bench for argmax_tree with directed and random vectors.
module tb_argmax_tree;

  localparam int S = 5;
  localparam int M = 8;
  localparam int E = 2**S;
  localparam int W = E*M;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] in;
  logic         out_valid;
  logic [M-1:0] max;
  logic [S-1:0] ind;

  typedef struct {
    int mx;
    int ix;
    int due;
  } exp_t;

  exp_t sbq[$];
  exp_t monE;
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  int   lastMx = 0;
  int   lastIx = 0;
  bit   monOn = 1'b0;

  argmax_tree #(.S(S), .M(M)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in(in),
    .out_valid(out_valid),
    .max(max),
    .ind(ind)
  );

  // free-running clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // reference ordering: true when a is preferred over the current best b
  function automatic bit better(input logic [M-1:0] a, input logic [M-1:0] b);
`ifdef ARGMAX_SIGNED_EN
    return $signed(a) > $signed(b);
`else
    return a > b;
`endif
  endfunction

  // linear scan: first occurrence of the largest element
  function automatic exp_t model(input logic [W-1:0] v);
    exp_t r;
    logic [M-1:0] best;
    best = v[M-1:0];
    r.ix = 0;
    for (int i = 1; i < E; i++) begin
      if (better(v[i*M +: M], best)) begin
        best = v[i*M +: M];
        r.ix = i;
      end
    end
    r.mx = int'(best);
    r.due = 0;
    return r;
  endfunction

  function automatic logic [W-1:0] fillAll(input logic [M-1:0] x);
    logic [W-1:0] v;
    for (int i = 0; i < E; i++) v[i*M +: M] = x;
    return v;
  endfunction

  task automatic checkOutput(input string name, input int act, input int req);
    checks++;
    if (act == req) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
  endtask

  // drive one cycle of input just after a rising edge; valid vectors enter the scoreboard
  task automatic applyStimulus(input logic [W-1:0] vec, input logic v);
    exp_t e;
    @(posedge clk);
    #1;
    in = vec;
    in_valid = v;
    if (v) begin
      e = model(vec);
      e.due = cyc + S;
      sbq.push_back(e);
    end
  endtask

  // monitor: pop and compare on each out_valid, otherwise confirm outputs hold
  always @(negedge clk) begin
    if (rst && monOn) begin
      if (out_valid) begin
        if (sbq.size() == 0) begin
          checkOutput("spurious_out_valid", 1, 0);
        end else begin
          monE = sbq.pop_front();
          checkOutput("max", int'(max), monE.mx);
          checkOutput("ind", int'(ind), monE.ix);
          checkOutput("latency_cycle", cyc, monE.due);
          lastMx = monE.mx;
          lastIx = monE.ix;
        end
      end else begin
        checkOutput("hold_max", int'(max), lastMx);
        checkOutput("hold_ind", int'(ind), lastIx);
      end
    end
  end

  // watchdog so the run always ends
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, pending %0d", sbq.size());
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [W-1:0] v;
    int wait_cnt;

    rst = 1'b0;
    in_valid = 1'b1;
    in = {E{8'hA5}};
    #3;
    checkOutput("reset_out_valid", int'(out_valid), 0);
    checkOutput("reset_max", int'(max), 0);
    checkOutput("reset_ind", int'(ind), 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    monOn = 1'b1;

    // single max: all 10, element 17 = 99
    v = fillAll(8'd10);
    v[17*M +: M] = 8'd99;
    applyStimulus(v, 1'b1);
    for (int i = 0; i < S + 2; i++) applyStimulus('0, 1'b0);

    // ties at 3, 20, 31
    v = fillAll(8'd5);
    v[3*M +: M] = 8'd200;
    v[20*M +: M] = 8'd200;
    v[31*M +: M] = 8'd200;
    applyStimulus(v, 1'b1);
    // all equal
    applyStimulus(fillAll(8'd42), 1'b1);
    // only last element nonzero
    v = '0;
    v[31*M +: M] = 8'd255;
    applyStimulus(v, 1'b1);
    // streaming: 7@2, 88@30, all zero
    v = '0;
    v[2*M +: M] = 8'd7;
    applyStimulus(v, 1'b1);
    v = fillAll(8'd1);
    v[30*M +: M] = 8'd88;
    applyStimulus(v, 1'b1);
    applyStimulus('0, 1'b1);
    // sign-mode vector: element 0 = 0x80, element 1 = 0x7F
    v = '0;
    v[0 +: M] = 8'h80;
    v[M +: M] = 8'h7F;
    applyStimulus(v, 1'b1);
    for (int i = 0; i < S + 2; i++) applyStimulus('0, 1'b0);

    // mid-flight reset: vector captured at edge N, reset pulsed between N+1 and N+2
    v = fillAll(8'd3);
    v[9*M +: M] = 8'd77;
    applyStimulus(v, 1'b1);
    applyStimulus('0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("midreset_out_valid", int'(out_valid), 0);
    checkOutput("midreset_max", int'(max), 0);
    checkOutput("midreset_ind", int'(ind), 0);
    sbq.delete();
    lastMx = 0;
    lastIx = 0;
    #1;
    rst = 1'b1;
    for (int i = 0; i < S + 4; i++) applyStimulus('0, 1'b0);

    // random traffic, mixing wide and narrow ranges to create ties
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < E; i++) begin
        if (n % 3 == 0) v[i*M +: M] = M'($urandom_range(0, 3));
        else v[i*M +: M] = M'($urandom);
      end
      applyStimulus(v, 1'($urandom_range(0, 3) != 0));
    end

    // drain
    wait_cnt = 0;
    applyStimulus('0, 1'b0);
    while (sbq.size() != 0 && wait_cnt < 4*S) begin
      @(posedge clk);
      wait_cnt++;
    end
    checkOutput("drain_pending", sbq.size(), 0);
    for (int i = 0; i < 3; i++) @(posedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
